// File: rtl/mipsfpga_io_debounce.sv
// Input conditioner for DE2-115 switches and pushbuttons. Each input is synchronized,
// debounced and, for the buttons, inverted so that 1 = pressed. Buttons also get a press strobe.
module mipsfpga_io_debounce #(
  parameter int N_SW            = 18,
  parameter int N_PB            = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            SI_ClkIn,
  input  logic            SI_Reset_N,
  input  logic [N_SW-1:0] SW,
  input  logic [N_PB-1:0] KEY,
  output logic [N_SW-1:0] IO_Switch,
  output logic [N_PB:0]   IO_PB,
  output logic [N_PB-1:0] pb_press
);

  localparam int N_CH = N_SW + N_PB;
  localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channels [N_SW-1:0] are switches and [N_CH-1:N_SW] are buttons.
  // Buttons are inverted ahead of the synchronizer, so the reset value 0 means "not pressed".
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] q;
  logic [N_CH-1:0] accept;
  logic [CW-1:0]   cnt [N_CH];

  assign raw = {~KEY, SW};

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    // The terminal count is reached only after s2 has differed from q for
    // DEBOUNCE_CYCLES consecutive edges; any agreement in between restarts it.
    assign accept[g] = (s2[g] != q[g]) && (cnt[g] == CNT_LAST);

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
      if (!SI_Reset_N) begin
        q[g]   <= 1'b0;
        cnt[g] <= '0;
      end else if (s2[g] == q[g]) begin
        cnt[g] <= '0;
      end else if (accept[g]) begin
        q[g]   <= s2[g];
        cnt[g] <= '0;
      end else begin
        cnt[g] <= cnt[g] + CW'(1);
      end
    end
  end

  // The strobe is registered alongside q, so it coincides with the 0->1 edge of IO_PB.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      pb_press <= '0;
    end else begin
      pb_press <= accept[N_CH-1:N_SW] & s2[N_CH-1:N_SW];
    end
  end

  assign IO_Switch = q[N_SW-1:0];
  assign IO_PB     = {1'b0, q[N_CH-1:N_SW]};

endmodule

// File: tb/tb_mipsfpga_io_debounce.sv
// Directed bench for mipsfpga_io_debounce with DEBOUNCE_CYCLES = 4. Expected values are
// worked out by hand from the documented latency: a pin change before edge 1 shows at edge 6.
module tb_mipsfpga_io_debounce;

  logic        clk;
  logic        rst_n;
  logic [17:0] sw;
  logic [3:0]  key;
  logic [17:0] io_switch;
  logic [4:0]  io_pb;
  logic [3:0]  pb_press;

  int n_vec;
  int n_err;
  int press_cnt [4];
  int pb4_seen;
  logic [7:0] bounce_pat;

  mipsfpga_io_debounce #(
    .N_SW(18),
    .N_PB(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .SI_ClkIn  (clk),
    .SI_Reset_N(rst_n),
    .SW        (sw),
    .KEY       (key),
    .IO_Switch (io_switch),
    .IO_PB     (io_pb),
    .pb_press  (pb_press)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and sample 1 ns later; counts strobes per button.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) if (pb_press[b]) press_cnt[b]++;
      if (io_pb[4]) pb4_seen++;
    end
  endtask

  task automatic clear_press();
    for (int b = 0; b < 4; b++) press_cnt[b] = 0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pb4_seen = 0;
    clear_press();
    rst_n = 1'b0;
    sw    = 18'h3FFFF;
    key   = 4'hF;

    // 1: reset with everything asserted at the pins
    tick(3);
    check_vec("rst_io_switch", 32'(io_switch), 32'h0);
    check_vec("rst_io_pb", 32'(io_pb), 32'h0);
    check_vec("rst_pb_press", 32'(pb_press), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check_vec("rst_sw_edge5", 32'(io_switch), 32'h0);
    tick(1);
    check_vec("rst_sw_edge6", 32'(io_switch), 32'h3FFFF);
    tick(2);
    check_vec("rst_no_strobe", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
    sw = 18'h0;
    tick(8);
    check_vec("sw_all_off", 32'(io_switch), 32'h0);

    // 2: clean press of KEY[1]
    clear_press();
    key = 4'b1101;
    tick(5);
    check_vec("press_edge5_pb", 32'(io_pb), 32'h00);
    check_vec("press_edge5_strb", 32'(pb_press), 32'h0);
    tick(1);
    check_vec("press_edge6_pb", 32'(io_pb), 32'h02);
    check_vec("press_edge6_strb", 32'(pb_press), 32'h2);
    tick(1);
    check_vec("press_edge7_strb", 32'(pb_press), 32'h0);
    check_vec("press_edge7_pb", 32'(io_pb), 32'h02);
    key = 4'hF;
    tick(8);
    check_vec("press_released", 32'(io_pb), 32'h00);
    check_vec("press_strobe_cnt", 32'(press_cnt[1]), 32'd1);

    // 3: bounce on KEY[0]: low 3, high 1, low 3, high 1, then hold low
    clear_press();
    bounce_pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      key[0] = bounce_pat[i];
      tick(1);
    end
    key[0] = 1'b0;
    tick(5);
    check_vec("bounce_pb0_held", 32'(io_pb[0]), 32'h0);
    check_vec("bounce_no_strobe", 32'(press_cnt[0]), 32'd0);
    tick(1);
    check_vec("bounce_pb0_accept", 32'(io_pb[0]), 32'h1);
    tick(4);
    check_vec("bounce_one_strobe", 32'(press_cnt[0]), 32'd1);
    key = 4'hF;
    tick(8);

    // 4: release of KEY[2] produces no strobe
    clear_press();
    key[2] = 1'b0;
    tick(6);
    check_vec("rel_pb2_pressed", 32'(io_pb[2]), 32'h1);
    check_vec("rel_press_strobe", 32'(press_cnt[2]), 32'd1);
    clear_press();
    key[2] = 1'b1;
    tick(5);
    check_vec("rel_edge5", 32'(io_pb[2]), 32'h1);
    tick(1);
    check_vec("rel_edge6", 32'(io_pb[2]), 32'h0);
    tick(2);
    check_vec("rel_no_strobe", 32'(press_cnt[2]), 32'd0);

    // 5: simultaneous events on SW[0], SW[17], KEY[3]
    clear_press();
    sw  = 18'h20001;
    key = 4'b0111;
    tick(5);
    check_vec("sim_edge5_sw", 32'(io_switch), 32'h0);
    check_vec("sim_edge5_pb", 32'(io_pb), 32'h00);
    tick(1);
    check_vec("sim_edge6_sw", 32'(io_switch), 32'h20001);
    check_vec("sim_edge6_pb", 32'(io_pb), 32'h08);
    check_vec("sim_edge6_strb", 32'(pb_press), 32'h8);
    tick(1);
    check_vec("sim_edge7_strb", 32'(pb_press), 32'h0);

    // 6: reset during SW[5] count; KEY[3] stays held through reset
    sw = 18'h20021;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_vec("midrst_async_sw", 32'(io_switch), 32'h0);
    check_vec("midrst_async_pb", 32'(io_pb), 32'h00);
    tick(2);
    check_vec("midrst_hold_sw", 32'(io_switch), 32'h0);
    rst_n = 1'b1;
    clear_press();
    tick(5);
    check_vec("midrst_edge5_sw", 32'(io_switch), 32'h0);
    tick(1);
    check_vec("midrst_edge6_sw", 32'(io_switch), 32'h20021);
    check_vec("midrst_edge6_pb", 32'(io_pb), 32'h08);
    check_vec("midrst_edge6_strb", 32'(pb_press), 32'h8);
    tick(2);
    check_vec("midrst_one_strobe", 32'(press_cnt[3]), 32'd1);

    check_vec("pb4_never_set", 32'(pb4_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mipsfpga_io_debounce.md
# mipsfpga_io_debounce

Input conditioner between the DE2-115 slide switches/pushbuttons and the `IO_Switch`/`IO_PB` ports of `mipsfpga_sys`. It does three things per input bit:
- synchronizes each raw pin into the processor clock domain;
- debounces it with a stability counter;
- inverts the active-low pushbuttons.

It also emits one-cycle press strobes so software-visible GPIO never sees bounce or metastability.

## Interface
Parameters:
- `N_SW`, default 18: number of slide-switch inputs.
- `N_PB`, default 4: number of pushbutton inputs (active-low at pins).
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before an output changes (10 ms at 50 MHz). Must be ≥ 2. The counter is `$clog2(DEBOUNCE_CYCLES)` bits wide per input.

Ports:
- `SI_ClkIn`, input, 1: processor clock; all state on its rising edge.
- `SI_Reset_N`, input, 1: reset, asynchronous assert, active-low.
- `SW`, input, `N_SW`: raw slide switches, asynchronous, 1 = on.
- `KEY`, input, `N_PB`: raw pushbuttons, asynchronous, 0 = pressed.
- `IO_Switch`, output, `N_SW`: debounced switches, 1 = on.
- `IO_PB`, output, `N_PB+1`: debounced buttons, 1 = pressed. Bit `N_PB` is tied to 0.
- `pb_press`, output, `N_PB`: one-cycle strobe on each debounced press (0→1 of `IO_PB[i]`).

## Operation
Each of the `N_SW+N_PB` inputs has an identical, independent channel.

- **Synchronizer:** two flops, `s1` then `s2`. `s2` is the synchronized level. For pushbuttons, `s2` is taken after inversion, so 1 = pressed.
- **Debounce state:** stable output `q` and counter `cnt`.
- **Counter rules, each clock:**
  - If `s2 == q`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `q <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Bounce rejection:** any return of `s2` to `q` before the terminal count clears `cnt`. A bounce therefore restarts the full interval.
- **Strobe:** `pb_press[i]` is registered. It is 1 exactly on the cycle in which `q` for button `i` transitions 0→1, and 0 otherwise. No strobe is generated on release or for switches.
- **No cross-coupling:** simultaneous events on different bits are fully independent.
- **Counter bound:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around is possible.

## Timing
- **Reset values while `SI_Reset_N`=0** (asynchronous, immediate):
  - switch `s1`/`s2` = 0;
  - button `s1`/`s2` = 0 (i.e. pins idle high, not pressed);
  - all `q` = 0, all `cnt` = 0;
  - `IO_Switch` = 0, `IO_PB` = 0, `pb_press` = 0.
- **After reset release:** a switch already on is reported after the normal latency. Switches produce no strobe. A button held through reset produces a strobe when it is accepted.
- **Latency:** a pin held at a new level sampled first at rising edge 1 gives `s2` updated at edge 2. `q` (and `pb_press`, if applicable) updates at edge `DEBOUNCE_CYCLES+2`.
- **Minimum accepted pulse:** the level must be present at `s2` for `DEBOUNCE_CYCLES` consecutive edges. Shorter pulses produce no output change.
- **Reset mid-count:** all progress is lost; outputs return to 0 asynchronously.
- **Outputs:** all are registered; no combinational path from pins to outputs.

## Test plan
Use `DEBOUNCE_CYCLES`=4 unless stated.

1. **Reset:** hold `SI_Reset_N`=0 with `SW`=18'h3FFFF and `KEY`=4'hF. Required: `IO_Switch`=0, `IO_PB`=5'h00, `pb_press`=0. Release reset. Required: `IO_Switch`=18'h3FFFF at edge 6 after release; `pb_press` stays 0.
2. **Clean press:** drive `KEY[1]` 1→0 before edge 1. Required:
   - `IO_PB`=5'h02 and `pb_press`=4'h2 exactly at edge 6;
   - `pb_press` back to 0 at edge 7;
   - `IO_PB[4]` is always 0.
3. **Bounce:** toggle `KEY[0]` low 3 cycles, high 1, low 3, high 1. Required: `IO_PB[0]` stays 0 and no strobe. Then hold low. Required: `IO_PB[0]`=1 exactly 6 edges after the final falling transition, with a single strobe.
4. **Release:** after `KEY[2]` is accepted as pressed, raise `KEY[2]`. Required: `IO_PB[2]`→0 at edge 6 and no strobe.
5. **Simultaneous events:** `SW[0]` rises, `SW[17]` rises, and `KEY[3]` falls on the same cycle. Required: all three outputs update on the same edge (6), and `pb_press`=4'h8 for one cycle.
6. **Reset mid-count:** `SW[5]` rises; assert `SI_Reset_N`=0 at edge 4 and release after 2 cycles with `SW[5]` still high. Required: `IO_Switch[5]`=0 through reset, then becomes 1 at edge 6 after release.
